fetch2_bundle_stage: RTL and testbench
======================================

Name: fetch2_bundle_stage

Overview:
Parametrised fetch-stage-2 for an N-wide front end. It pre-decodes a fetched bundle and validates BTB predictions per lane, masking lanes after the first taken control transfer. It raises a BTB-miss redirect, allocates CTI-queue tags with a credit counter, and registers the result into a valid/ready output stage feeding decode. It replaces the fixed 4-wide stage with width/depth generality, backpressure and flush/restore.

Parameters:
FETCH_WIDTH, 4, lanes per bundle (power of 2, 1..8)
PC_W, 32, PC width
INST_W, 64, instruction width; lane i PC = pc + 8*i
CTIQ_DEPTH, 16, CTI-queue entries (power of 2)
CTIQ_LOG, 4, log2(CTIQ_DEPTH)
CMT_W, 3, width of commit count (max commits per cycle <= 2^CMT_W-1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
flush_i  in  1  backend recovery; kills output stage and restores CTI state
flush_tail_i  in  CTIQ_LOG  restored CTI tail pointer
flush_count_i  in  CTIQ_LOG+1  restored CTI occupancy (pre-commit of this cycle)
in_valid_i  in  1  bundle present
in_ready_o  out  1  bundle accepted when in_valid_i & in_ready_o
pc_i  in  PC_W  PC of lane 0
bundle_i  in  FETCH_WIDTH*INST_W  lane i at [i*INST_W +: INST_W]
btb_hit_i  in  FETCH_WIDTH  per-lane BTB hit
btb_target_i  in  FETCH_WIDTH*PC_W  per-lane BTB target
pred_i  in  FETCH_WIDTH  per-lane direction prediction
ras_addr_i  in  PC_W  RAS top
commit_cnt_i  in  CMT_W  CTIs retired this cycle
out_valid_o  out  1  output bundle valid
out_ready_i  in  1  decode accepts
out_pc_o  out  PC_W  registered pc_i
out_bundle_o  out  FETCH_WIDTH*INST_W  registered bundle
out_lane_valid_o  out  FETCH_WIDTH  bit i = lane i valid
out_target_o  out  FETCH_WIDTH*PC_W  per-lane final target
out_tag_o  out  FETCH_WIDTH*CTIQ_LOG  per-lane CTI tag
out_pred_o  out  FETCH_WIDTH  registered pred_i
redirect_valid_o  out  1  one-cycle BTB-miss redirect
redirect_pc_o  out  PC_W  redirect target
redirect_rtr_o / redirect_call_o  out  1 each  redirecting CTI is return / call
call_pc_o  out  PC_W  PC of redirecting CTI
ctiq_full_o  out  1  bundle stalled for lack of CTI credits
ctiq_count_o  out  CTIQ_LOG+1  current occupancy

Behaviour:
- ctrl_type encoding: 00 return, 01 call, 10 jump, 11 conditional. taken[i] = is_ctrl[i] & (pred[i] | type!=11).
- k = lowest taken lane. Lane mask: bits 0..k set; no taken lane -> all set.
- need = popcount(is_ctrl[i] for i<=k, or all lanes if none taken). Lane i tag = (tail + #ctrl lanes below i) mod CTIQ_DEPTH.
- credit_ok = count + need <= CTIQ_DEPTH. in_ready_o = credit_ok & (~out_valid_o | out_ready_i) & ~flush_i. ctiq_full_o = in_valid_i & ~credit_ok.
- Redirect when taken lane k has ~btb_hit[k]. Target is ras_addr_i for a return, else the predecoded target. out_target_o lane k takes the same value. Call flag when type 01.
- Accept: latch all out_* fields and set out_valid_o at the next edge (latency 1). redirect_valid_o pulses for exactly that one cycle (registered), independent of out_ready_i. tail += need.
- Output hold: out_valid_o & ~out_ready_i leaves all out_* stable. Drain without new accept clears out_valid_o.
- count_next = count + (accept ? need : 0) - commit_cnt_i, with simultaneous alloc and commit legal. commit_cnt_i > count is illegal (assert). Tail wraps mod depth.
- flush_i has priority:
  - out_valid_o and redirect_valid_o go to 0.
  - tail <= flush_tail_i.
  - count <= flush_count_i - commit_cnt_i.
  - No accept that cycle.
- Reset: out_valid_o=0, redirect_valid_o=0, all registered data=0, tail=0, count=0, ctiq_full_o follows its equation. Reset mid-stall discards the held bundle.

Optional Feature:
FS2_PERF_CNT_EN:
- Defined: adds 32-bit outputs perf_redirect_o (counts redirect_valid_o pulses) and perf_ctiq_stall_o (counts cycles with ctiq_full_o=1). Both saturate, clear on reset, and do not clear on flush.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared fabscalar package/header: ctrl_type encodings, lane PC stride (8), CTIQ_DEPTH/CTIQ_LOG defaults.
- Sub-module fs2_predecode_lane, combinational, instanced FETCH_WIDTH times: PISA opcode -> is_ctrl, ctrl_type, direct target (BTB target for indirect).
- Top keeps priority scan, prefix-count tags, credit counter and output register.

Test Plan:
1. FETCH_WIDTH=4, no CTIs, pc_i=0x1000, out_ready_i=1 -> next cycle out_valid_o=1, lane mask 1111, count stays 0.
2. Lane 1 conditional, pred=1, btb_hit=0, target 0x2000 -> mask 0011, redirect_valid_o one cycle with redirect_pc_o=0x2000, tag lane1=0, count=1.
3. Lane 2 return, btb_hit=0, ras_addr_i=0x3450 -> redirect_pc_o=0x3450, redirect_rtr_o=1, out_target_o lane2=0x3450, mask 0111.
4. count=15, bundle with 2 CTIs -> ctiq_full_o=1, in_ready_o=0; commit_cnt_i=1 same cycle -> count 14, accept next cycle, count=16.
5. out_ready_i=0 for 3 cycles with in_valid_i held -> out_* stable, in_ready_o=0, no repeated redirect pulse.
6. flush_i with flush_tail_i=5, flush_count_i=3, commit_cnt_i=1, held output -> out_valid_o=0, count=2, next tag issued =5.

Source files
------------

// File: rtl/fetch2_bundle_stage_pkg.sv
// Shared fetch-2 definitions: control-transfer encodings, PISA opcode map and lane PC stride.
package fetch2_bundle_stage_pkg;

    typedef enum logic [1:0] {
        CT_RTN  = 2'b00,
        CT_CALL = 2'b01,
        CT_JUMP = 2'b10,
        CT_COND = 2'b11
    } ctrl_type_e;

    localparam int LANE_STRIDE    = 8;
    localparam int CTIQ_DEPTH_DEF = 16;
    localparam int CTIQ_LOG_DEF   = 4;

    // PISA fields: opcode in inst[39:32], rs in inst[31:24], J-target in inst[25:0], branch imm in inst[15:0]
    localparam int         OP_LSB   = 32;
    localparam int         RS_LSB   = 24;
    localparam logic [7:0] RA_REG   = 8'd31;
    localparam logic [7:0] OP_J     = 8'h01;
    localparam logic [7:0] OP_JAL   = 8'h02;
    localparam logic [7:0] OP_JR    = 8'h03;
    localparam logic [7:0] OP_JALR  = 8'h04;
    localparam logic [7:0] OP_BR_LO = 8'h05;
    localparam logic [7:0] OP_BR_HI = 8'h0A;

endpackage

// File: rtl/fs2_predecode_lane.sv
// Per-lane combinational predecode: classifies the PISA opcode and forms the control-transfer target.
module fs2_predecode_lane
    import fetch2_bundle_stage_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int INST_W = 64
) (
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   btb_target_i,
    output logic              is_ctrl_o,
    output ctrl_type_e        ctrl_type_o,
    output logic [PC_W-1:0]   target_o
);

    logic [7:0]      op;
    logic [7:0]      rs;
    logic [PC_W-1:0] off;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] jmp_tgt;
    logic            unused_hi;

    assign op        = inst_i[OP_LSB +: 8];
    assign rs        = inst_i[RS_LSB +: 8];
    assign off       = PC_W'($signed(inst_i[15:0]));
    // Branch offsets count 8-byte instructions relative to the following PC.
    assign br_tgt    = pc_i + PC_W'(LANE_STRIDE) + (off << 3);
    assign jmp_tgt   = (pc_i & ~PC_W'(32'h0FFF_FFFF)) | PC_W'({inst_i[25:0], 2'b00});
    assign unused_hi = ^inst_i[INST_W-1:OP_LSB+8];

    always_comb begin
        is_ctrl_o   = 1'b1;
        ctrl_type_o = CT_COND;
        target_o    = br_tgt;
        if (op == OP_J || op == OP_JAL) begin
            ctrl_type_o = (op == OP_JAL) ? CT_CALL : CT_JUMP;
            target_o    = jmp_tgt;
        end else if (op == OP_JR) begin
            ctrl_type_o = (rs == RA_REG) ? CT_RTN : CT_JUMP;
            target_o    = btb_target_i;
        end else if (op == OP_JALR) begin
            ctrl_type_o = CT_CALL;
            target_o    = btb_target_i;
        end else if (op < OP_BR_LO || op > OP_BR_HI) begin
            is_ctrl_o = 1'b0;
            target_o  = pc_i + PC_W'(LANE_STRIDE);
        end
    end

endmodule

// File: rtl/fetch2_bundle_stage.sv
// Fetch stage 2: predecode, first-taken lane masking, BTB-miss redirect, CTI-queue credits, output register.
// Optional FS2_PERF_CNT_EN adds saturating redirect / CTI-stall counters.
module fetch2_bundle_stage
    import fetch2_bundle_stage_pkg::*;
#(
    parameter int FETCH_WIDTH = 4,
    parameter int PC_W        = 32,
    parameter int INST_W      = 64,
    parameter int CTIQ_DEPTH  = CTIQ_DEPTH_DEF,
    parameter int CTIQ_LOG    = CTIQ_LOG_DEF,
    parameter int CMT_W       = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic [CTIQ_LOG-1:0]             flush_tail_i,
    input  logic [CTIQ_LOG:0]               flush_count_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [PC_W-1:0]                 pc_i,
    input  logic [FETCH_WIDTH*INST_W-1:0]   bundle_i,
    input  logic [FETCH_WIDTH-1:0]          btb_hit_i,
    input  logic [FETCH_WIDTH*PC_W-1:0]     btb_target_i,
    input  logic [FETCH_WIDTH-1:0]          pred_i,
    input  logic [PC_W-1:0]                 ras_addr_i,
    input  logic [CMT_W-1:0]                commit_cnt_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [PC_W-1:0]                 out_pc_o,
    output logic [FETCH_WIDTH*INST_W-1:0]   out_bundle_o,
    output logic [FETCH_WIDTH-1:0]          out_lane_valid_o,
    output logic [FETCH_WIDTH*PC_W-1:0]     out_target_o,
    output logic [FETCH_WIDTH*CTIQ_LOG-1:0] out_tag_o,
    output logic [FETCH_WIDTH-1:0]          out_pred_o,
    output logic                            redirect_valid_o,
    output logic [PC_W-1:0]                 redirect_pc_o,
    output logic                            redirect_rtr_o,
    output logic                            redirect_call_o,
    output logic [PC_W-1:0]                 call_pc_o,
    output logic                            ctiq_full_o,
    output logic [CTIQ_LOG:0]               ctiq_count_o
`ifdef FS2_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_redirect_o,
    output logic [31:0]                     perf_ctiq_stall_o
`endif
);

    localparam int CNT_W  = CTIQ_LOG + 1;
    localparam int NEED_W = $clog2(FETCH_WIDTH + 1);
    localparam int SUM_W  = (CNT_W + 1 > NEED_W + 1) ? CNT_W + 1 : NEED_W + 1;
    localparam int LW     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic [FETCH_WIDTH-1:0][INST_W-1:0]   inst;
    logic [FETCH_WIDTH-1:0][PC_W-1:0]     lane_pc, btb_tgt, pd_tgt, tgt_fin;
    logic [FETCH_WIDTH-1:0][CTIQ_LOG-1:0] tag;
    logic [FETCH_WIDTH-1:0]               is_ctrl, taken, mask;
    ctrl_type_e                           pd_type [FETCH_WIDTH];

    logic                found, redir, credit_ok, accept;
    logic [LW-1:0]       k;
    logic [NEED_W-1:0]   need;
    logic [CTIQ_LOG-1:0] pre;
    ctrl_type_e          k_type;
    logic [PC_W-1:0]     redir_pc;

    logic                                 out_valid_q, out_valid_d, redir_vld_q, redir_vld_d;
    logic [CTIQ_LOG-1:0]                  tail_q, tail_d;
    logic [CNT_W-1:0]                     count_q, count_d;
    logic [PC_W-1:0]                      out_pc_q, redir_pc_q, call_pc_q;
    logic [FETCH_WIDTH*INST_W-1:0]        out_bundle_q;
    logic [FETCH_WIDTH-1:0]               mask_q, pred_q;
    logic [FETCH_WIDTH-1:0][PC_W-1:0]     tgt_q;
    logic [FETCH_WIDTH-1:0][CTIQ_LOG-1:0] tag_q;
    logic                                 rtr_q, call_q;

    assign inst    = bundle_i;
    assign btb_tgt = btb_target_i;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
        assign lane_pc[g] = pc_i + PC_W'(LANE_STRIDE * g);
        fs2_predecode_lane #(.PC_W(PC_W), .INST_W(INST_W)) u_pd (
            .inst_i      (inst[g]),
            .pc_i        (lane_pc[g]),
            .btb_target_i(btb_tgt[g]),
            .is_ctrl_o   (is_ctrl[g]),
            .ctrl_type_o (pd_type[g]),
            .target_o    (pd_tgt[g])
        );
        assign taken[g] = is_ctrl[g] & (pred_i[g] | (pd_type[g] != CT_COND));
    end

    // Tags are handed out to every CTI lane in order; credits only cover lanes up to the first taken one.
    always_comb begin
        found = 1'b0;
        k     = '0;
        mask  = '0;
        need  = '0;
        pre   = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            tag[i] = tail_q + pre;
            if (is_ctrl[i]) pre = pre + CTIQ_LOG'(1);
            if (!found) begin
                mask[i] = 1'b1;
                if (is_ctrl[i]) need = need + NEED_W'(1);
                if (taken[i]) begin
                    found = 1'b1;
                    k     = LW'(i);
                end
            end
        end
    end

    assign k_type   = pd_type[k];
    assign redir    = found & ~btb_hit_i[k];
    assign redir_pc = (k_type == CT_RTN) ? ras_addr_i : pd_tgt[k];

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++)
            tgt_fin[i] = (redir && k == LW'(i)) ? redir_pc : pd_tgt[i];
    end

    assign credit_ok   = (SUM_W'(count_q) + SUM_W'(need)) <= SUM_W'(CTIQ_DEPTH);
    assign in_ready_o  = credit_ok & (~out_valid_q | out_ready_i) & ~flush_i;
    assign ctiq_full_o = in_valid_i & ~credit_ok;
    assign accept      = in_valid_i & in_ready_o;
    assign redir_vld_d = accept & redir;

    always_comb begin
        out_valid_d = out_valid_q;
        tail_d      = tail_q;
        count_d     = count_q - CNT_W'(commit_cnt_i);
        if (flush_i) begin
            out_valid_d = 1'b0;
            tail_d      = flush_tail_i;
            count_d     = flush_count_i - CNT_W'(commit_cnt_i);
        end else if (accept) begin
            out_valid_d = 1'b1;
            tail_d      = tail_q + CTIQ_LOG'(need);
            count_d     = count_q + CNT_W'(need) - CNT_W'(commit_cnt_i);
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            redir_vld_q  <= 1'b0;
            tail_q       <= '0;
            count_q      <= '0;
            out_pc_q     <= '0;
            out_bundle_q <= '0;
            mask_q       <= '0;
            pred_q       <= '0;
            tgt_q        <= '0;
            tag_q        <= '0;
            redir_pc_q   <= '0;
            rtr_q        <= 1'b0;
            call_q       <= 1'b0;
            call_pc_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            redir_vld_q <= redir_vld_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            if (accept) begin
                out_pc_q     <= pc_i;
                out_bundle_q <= bundle_i;
                mask_q       <= mask;
                pred_q       <= pred_i;
                tgt_q        <= tgt_fin;
                tag_q        <= tag;
                if (redir) begin
                    redir_pc_q <= redir_pc;
                    rtr_q      <= (k_type == CT_RTN);
                    call_q     <= (k_type == CT_CALL);
                    call_pc_q  <= lane_pc[k];
                end
            end
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_pc_o         = out_pc_q;
    assign out_bundle_o     = out_bundle_q;
    assign out_lane_valid_o = mask_q;
    assign out_target_o     = tgt_q;
    assign out_tag_o        = tag_q;
    assign out_pred_o       = pred_q;
    assign redirect_valid_o = redir_vld_q;
    assign redirect_pc_o    = redir_pc_q;
    assign redirect_rtr_o   = rtr_q;
    assign redirect_call_o  = call_q;
    assign call_pc_o        = call_pc_q;
    assign ctiq_count_o     = count_q;

`ifdef FS2_PERF_CNT_EN
    logic [31:0] perf_redir_q, perf_stall_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_redir_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (redir_vld_q && perf_redir_q != '1) perf_redir_q <= perf_redir_q + 32'd1;
            if (ctiq_full_o && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end
    assign perf_redirect_o   = perf_redir_q;
    assign perf_ctiq_stall_o = perf_stall_q;
`endif

    // Retiring more CTIs than are allocated means the backend lost track of the queue.
    a_commit_le_count : assert property (@(posedge clk) disable iff (!reset)
        (flush_i ? (CNT_W'(commit_cnt_i) <= flush_count_i) : (CNT_W'(commit_cnt_i) <= count_q)));

endmodule

// File: tb/tb_fetch2_bundle_stage.sv
// Self-checking bench for fetch2_bundle_stage: directed scenarios plus random traffic against a lane-level model.
module tb_fetch2_bundle_stage;

    localparam int FW    = 4;
    localparam int PW    = 32;
    localparam int IW    = 64;
    localparam int DEPTH = 16;
    localparam int LOG   = 4;
    localparam int CW    = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              flush_i, in_valid_i, out_ready_i;
    logic [LOG-1:0]    flush_tail_i;
    logic [LOG:0]      flush_count_i;
    logic [PW-1:0]     pc_i, ras_addr_i;
    logic [FW*IW-1:0]  bundle_i;
    logic [FW-1:0]     btb_hit_i, pred_i;
    logic [FW*PW-1:0]  btb_target_i;
    logic [CW-1:0]     commit_cnt_i;
    logic              in_ready_o, out_valid_o, redirect_valid_o, redirect_rtr_o, redirect_call_o, ctiq_full_o;
    logic [PW-1:0]     out_pc_o, redirect_pc_o, call_pc_o;
    logic [FW*IW-1:0]  out_bundle_o;
    logic [FW-1:0]     out_lane_valid_o, out_pred_o;
    logic [FW*PW-1:0]  out_target_o;
    logic [FW*LOG-1:0] out_tag_o;
    logic [LOG:0]      ctiq_count_o;
`ifdef FS2_PERF_CNT_EN
    logic [31:0]       perf_redirect_o, perf_ctiq_stall_o;
`endif

    fetch2_bundle_stage #(.FETCH_WIDTH(FW), .PC_W(PW), .INST_W(IW), .CTIQ_DEPTH(DEPTH),
                          .CTIQ_LOG(LOG), .CMT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .flush_tail_i(flush_tail_i),
        .flush_count_i(flush_count_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .bundle_i(bundle_i), .btb_hit_i(btb_hit_i), .btb_target_i(btb_target_i),
        .pred_i(pred_i), .ras_addr_i(ras_addr_i), .commit_cnt_i(commit_cnt_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
        .out_bundle_o(out_bundle_o), .out_lane_valid_o(out_lane_valid_o),
        .out_target_o(out_target_o), .out_tag_o(out_tag_o), .out_pred_o(out_pred_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_rtr_o(redirect_rtr_o), .redirect_call_o(redirect_call_o),
        .call_pc_o(call_pc_o), .ctiq_full_o(ctiq_full_o), .ctiq_count_o(ctiq_count_o)
`ifdef FS2_PERF_CNT_EN
        , .perf_redirect_o(perf_redirect_o), .perf_ctiq_stall_o(perf_ctiq_stall_o)
`endif
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state
    int          m_tail, m_count;
    bit          m_ov, m_rv, m_rtr, m_call;
    logic [31:0] m_pc, m_rpc, m_cpc;
    logic [255:0] m_bundle;
    logic [3:0]  m_mask, m_pred;
    logic [31:0] m_tgt [FW];
    int          m_tag [FW];
    bit          s_ready, s_full;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] op, input logic [7:0] rs, input logic [25:0] imm);
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        v[25:0] = imm;
        if (op == 8'h03 || op == 8'h04) v[31:24] = rs;
        v[39:32] = op;
        return v;
    endfunction

    function automatic logic [63:0] mk_nop();
        return mk(8'h20 + 8'($urandom_range(0, 200)), 8'd0, 26'($urandom()));
    endfunction

    function automatic logic [63:0] rnd_inst();
        int r = $urandom_range(0, 15);
        logic [7:0] op;
        if (r < 8)       return mk_nop();
        else if (r == 8) op = 8'h01;
        else if (r == 9) op = 8'h02;
        else if (r < 12) op = 8'h03;
        else if (r == 12) op = 8'h04;
        else             op = 8'(5 + $urandom_range(0, 5));
        return mk(op, (r == 10) ? 8'd31 : 8'($urandom_range(0, 40)), 26'($urandom()));
    endfunction

    // Decode by the PISA rules: type 0 return, 1 call, 2 jump, 3 conditional.
    function automatic void dec(input logic [63:0] inst, input logic [31:0] pc, input logic [31:0] btb,
                                output bit c, output int t, output logic [31:0] tg);
        int op  = int'(inst[39:32]);
        int off = int'($signed(inst[15:0]));
        c = 1'b1;
        t = 3;
        tg = pc + 32'(8 + off * 8);
        if (op == 1 || op == 2) begin
            t  = (op == 2) ? 1 : 2;
            tg = (pc & 32'hF000_0000) | {4'h0, inst[25:0], 2'b00};
        end else if (op == 3) begin
            t  = (inst[31:24] == 8'd31) ? 0 : 2;
            tg = btb;
        end else if (op == 4) begin
            t  = 1;
            tg = btb;
        end else if (op < 5 || op > 10) begin
            c  = 1'b0;
            tg = pc + 32'd8;
        end
    endfunction

    task automatic model_reset();
        m_tail = 0; m_count = 0; m_ov = 0; m_rv = 0; m_rtr = 0; m_call = 0;
        m_pc = 0; m_rpc = 0; m_cpc = 0; m_bundle = 0; m_mask = 0; m_pred = 0;
        for (int i = 0; i < FW; i++) begin m_tgt[i] = 0; m_tag[i] = 0; end
    endtask

    task automatic set_idle();
        flush_i = 0; flush_tail_i = 0; flush_count_i = 0; in_valid_i = 0; out_ready_i = 1;
        pc_i = 32'h1000; ras_addr_i = 0; btb_hit_i = 0; pred_i = 0; commit_cnt_i = 0;
        for (int i = 0; i < FW; i++) begin
            bundle_i[i*IW +: IW] = mk_nop();
            btb_target_i[i*PW +: PW] = $urandom() & 32'hFFFF_FFF8;
        end
    endtask

    // One clock: check handshake before the edge, advance the model, check registers after it.
    task automatic cycle();
        bit c [FW];
        int t [FW];
        logic [31:0] tg [FW];
        int k, need, below;
        bit credit, er, ef, acc;
        @(negedge clk);
        for (int i = 0; i < FW; i++)
            dec(bundle_i[i*IW +: IW], pc_i + 32'(8 * i), btb_target_i[i*PW +: PW], c[i], t[i], tg[i]);
        k = -1; need = 0;
        for (int i = 0; i < FW; i++)
            if (k < 0) begin
                if (c[i]) need++;
                if (c[i] && (pred_i[i] || t[i] != 3)) k = i;
            end
        credit = (m_count + need) <= DEPTH;
        er = credit && (!m_ov || out_ready_i) && !flush_i;
        ef = in_valid_i && !credit;
        s_ready = in_ready_o;
        s_full  = ctiq_full_o;
        chk("in_ready", in_ready_o, er);
        chk("ctiq_full", ctiq_full_o, ef);
        acc = in_valid_i && er;
        if (flush_i) begin
            m_ov = 0; m_rv = 0;
            m_tail = int'(flush_tail_i);
            m_count = int'(flush_count_i) - int'(commit_cnt_i);
        end else begin
            if (acc) begin
                m_ov = 1; m_pc = pc_i; m_bundle = bundle_i; m_pred = pred_i;
                m_mask = (k < 0) ? 4'hF : 4'((1 << (k + 1)) - 1);
                below = 0;
                for (int i = 0; i < FW; i++) begin
                    m_tag[i] = (m_tail + below) % DEPTH;
                    if (c[i]) below++;
                    m_tgt[i] = tg[i];
                end
                m_rv = (k >= 0) && !btb_hit_i[k];
                if (m_rv) begin
                    m_rpc = (t[k] == 0) ? ras_addr_i : tg[k];
                    m_tgt[k] = m_rpc;
                    m_rtr = (t[k] == 0);
                    m_call = (t[k] == 1);
                    m_cpc = pc_i + 32'(8 * k);
                end
                m_tail = (m_tail + need) % DEPTH;
            end else begin
                m_rv = 0;
                if (out_ready_i) m_ov = 0;
            end
            m_count = m_count + (acc ? need : 0) - int'(commit_cnt_i);
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid_o, m_ov);
        chk("redirect_valid", redirect_valid_o, m_rv);
        chk("ctiq_count", ctiq_count_o, m_count);
        if (m_ov) begin
            chk("out_pc", out_pc_o, m_pc);
            chk("out_bundle", out_bundle_o, m_bundle);
            chk("lane_mask", out_lane_valid_o, m_mask);
            chk("out_pred", out_pred_o, m_pred);
            for (int i = 0; i < FW; i++) begin
                chk($sformatf("target%0d", i), out_target_o[i*PW +: PW], m_tgt[i]);
                chk($sformatf("tag%0d", i), out_tag_o[i*LOG +: LOG], m_tag[i]);
            end
        end
        if (m_rv) begin
            chk("redirect_pc", redirect_pc_o, m_rpc);
            chk("redirect_rtr", redirect_rtr_o, m_rtr);
            chk("redirect_call", redirect_call_o, m_call);
            chk("call_pc", call_pc_o, m_cpc);
        end
    endtask

    initial begin
        model_reset();
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_redirect", redirect_valid_o, 1'b0);
        chk("rst_count", ctiq_count_o, 0);
        chk("rst_out_pc", out_pc_o, 0);
        chk("rst_bundle", out_bundle_o, 0);
        chk("rst_tags", out_tag_o, 0);
        chk("rst_full", ctiq_full_o, 1'b0);
        reset = 1;

        // 1: plain bundle, no CTIs
        in_valid_i = 1;
        cycle();
        chk("t1_mask", out_lane_valid_o, 4'b1111);
        chk("t1_valid", out_valid_o, 1'b1);
        chk("t1_count", ctiq_count_o, 0);

        // 2: lane 1 predicted-taken conditional missing in BTB
        set_idle(); in_valid_i = 1;
        bundle_i[1*IW +: IW] = mk(8'h05, 8'd0, 26'h01FE);
        pred_i = 4'b0010;
        cycle();
        chk("t2_mask", out_lane_valid_o, 4'b0011);
        chk("t2_redirect", redirect_valid_o, 1'b1);
        chk("t2_redirect_pc", redirect_pc_o, 32'h2000);
        chk("t2_tag1", out_tag_o[1*LOG +: LOG], 0);
        chk("t2_count", ctiq_count_o, 1);
        set_idle();
        cycle();
        chk("t2_pulse_once", redirect_valid_o, 1'b0);

        // 3: lane 2 return missing in BTB, target from RAS
        set_idle(); in_valid_i = 1; ras_addr_i = 32'h3450;
        bundle_i[2*IW +: IW] = mk(8'h03, 8'd31, 26'h0);
        cycle();
        chk("t3_redirect_pc", redirect_pc_o, 32'h3450);
        chk("t3_rtr", redirect_rtr_o, 1'b1);
        chk("t3_target2", out_target_o[2*PW +: PW], 32'h3450);
        chk("t3_mask", out_lane_valid_o, 4'b0111);

        // 4: fill CTI queue to 15, then a 2-CTI bundle must wait for a commit
        for (int b = 0; b < 3; b++) begin
            set_idle(); in_valid_i = 1;
            for (int i = 0; i < FW; i++) bundle_i[i*IW +: IW] = mk(8'h06, 8'd0, 26'($urandom()));
            cycle();
        end
        set_idle(); in_valid_i = 1;
        bundle_i[0 +: IW] = mk(8'h07, 8'd0, 26'h10);
        cycle();
        chk("t4_count15", ctiq_count_o, 15);
        set_idle(); in_valid_i = 1; commit_cnt_i = 1;
        bundle_i[0 +: IW]  = mk(8'h05, 8'd0, 26'h20);
        bundle_i[IW +: IW] = mk(8'h08, 8'd0, 26'h30);
        cycle();
        chk("t4_full", s_full, 1'b1);
        chk("t4_not_ready", s_ready, 1'b0);
        chk("t4_count14", ctiq_count_o, 14);
        commit_cnt_i = 0;
        cycle();
        chk("t4_count16", ctiq_count_o, 16);

        // 5: backpressure holds a redirecting bundle without re-pulsing
        set_idle(); commit_cnt_i = 4;
        cycle();
        set_idle(); in_valid_i = 1; pc_i = 32'h5000; out_ready_i = 0;
        bundle_i[0 +: IW] = mk(8'h01, 8'd0, 26'h0000_400);
        cycle();
        chk("t5_redirect", redirect_valid_o, 1'b1);
        pc_i = 32'h6000;
        repeat (3) cycle();
        chk("t5_held_pc", out_pc_o, 32'h5000);
        chk("t5_no_repulse", redirect_valid_o, 1'b0);
        chk("t5_stalled", s_ready, 1'b0);

        // 6: flush restores CTI state and kills the held output
        flush_i = 1; flush_tail_i = 5; flush_count_i = 3; commit_cnt_i = 1;
        cycle();
        chk("t6_out_valid", out_valid_o, 1'b0);
        chk("t6_count", ctiq_count_o, 2);
        set_idle(); in_valid_i = 1;
        bundle_i[0 +: IW] = mk(8'h09, 8'd0, 26'h44);
        cycle();
        chk("t6_tag0", out_tag_o[0 +: LOG], 5);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            set_idle();
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 9) < 7);
            pc_i        = $urandom() & 32'hFFFF_FFF8;
            ras_addr_i  = $urandom() & 32'hFFFF_FFF8;
            btb_hit_i   = 4'($urandom());
            pred_i      = 4'($urandom());
            for (int i = 0; i < FW; i++) bundle_i[i*IW +: IW] = rnd_inst();
            if ($urandom_range(0, 19) == 0) begin
                flush_i = 1;
                flush_tail_i = 4'($urandom());
                flush_count_i = 5'($urandom_range(0, DEPTH));
                commit_cnt_i = 3'($urandom_range(0, (flush_count_i < 7) ? int'(flush_count_i) : 7));
            end else begin
                commit_cnt_i = 3'($urandom_range(0, (m_count < 7) ? m_count : 7));
            end
            cycle();
        end

        // Reset while a bundle is stalled in the output register
        set_idle(); in_valid_i = 1; out_ready_i = 0;
        cycle();
        cycle();
        #1 reset = 0;
        #1;
        chk("rst_mid_valid", out_valid_o, 1'b0);
        chk("rst_mid_redirect", redirect_valid_o, 1'b0);
        chk("rst_mid_count", ctiq_count_o, 0);
        model_reset();
        set_idle();
        @(posedge clk);
        #1 reset = 1;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
